// File: rtl/turbo_if_pkg.sv
// Shared defaults, counter widths and the parameter-legality check for the
// turbo decoder input path.
package turbo_if_pkg;

  localparam int BUS_DEF                   = 534;
  localparam int ST_PER_BUS_DEF            = 512;
  localparam int ST_DEF                    = 8;
  localparam int NUM_ST_PER_BUS_DEF        = 64;
  localparam int NUM_BUS_PER_TURBO_PKT_DEF = 25;
  localparam int ST_PER_TURBO_PKT_DEF      = 1542;

  localparam int BEAT_W = $clog2(NUM_ST_PER_BUS_DEF);
  localparam int WORD_W = $clog2(NUM_BUS_PER_TURBO_PKT_DEF);
  localparam int PKT_W  = $clog2(ST_PER_TURBO_PKT_DEF);

  // IDLE: sitting on a packet boundary. STREAM: a packet is part-way out.
  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  // The last bus word of a packet must carry at least one beat, and the
  // payload must slice evenly into stream beats.
  function automatic logic params_legal(input int bus, input int st_per_bus,
                                        input int st, input int num_st,
                                        input int num_bus, input int st_pkt);
    return (bus >= st_per_bus) && (st * num_st == st_per_bus) &&
           ((num_bus - 1) * num_st < st_pkt) && (st_pkt <= num_bus * num_st);
  endfunction

endpackage

// File: rtl/bus2st_pingpong.sv
// Two-entry word store: alternating write/read slots with an occupancy count.
module bus2st_pingpong #(
  parameter int W = 512
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         pop_i,
  output logic [W-1:0] rd_data_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic [1:0]   count_d;

  // Payload slots carry no reset; only the bookkeeping below is reset.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // Occupancy: a push and pop in the same cycle cancel out.
  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) wr_ptr_q <= ~wr_ptr_q;
      if (pop_i)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign full_o    = (count_q == 2'd2);
  assign empty_o   = (count_q == 2'd0);

endmodule

// File: rtl/bus2st_tx.sv
// Bus-word to Avalon-ST serializer: buffers two words and emits ST-bit beats,
// lowest slice first, framing each turbo packet with sop/eop.
module bus2st_tx
  import turbo_if_pkg::*;
#(
  parameter int BUS                   = BUS_DEF,
  parameter int ST_PER_BUS            = ST_PER_BUS_DEF,
  parameter int ST                    = ST_DEF,
  parameter int NUM_ST_PER_BUS        = NUM_ST_PER_BUS_DEF,
  parameter int NUM_BUS_PER_TURBO_PKT = NUM_BUS_PER_TURBO_PKT_DEF,
  parameter int ST_PER_TURBO_PKT      = ST_PER_TURBO_PKT_DEF
) (
  input  logic           clk_bus,
  input  logic           rst_n,
  input  logic [BUS-1:0] bus_data,
  input  logic           bus_en,
  output logic           bus_ready,
  output logic [ST-1:0]  st_data,
  output logic           st_valid,
  output logic           st_sop,
  output logic           st_eop,
  input  logic           st_ready,
  output logic           pkt_done,
  output logic           err_overflow
);

  localparam int BEAT_BITS = $clog2(NUM_ST_PER_BUS);
  localparam int WORD_BITS = $clog2(NUM_BUS_PER_TURBO_PKT);
  localparam int PKT_BITS  = $clog2(ST_PER_TURBO_PKT);
  localparam logic [BEAT_BITS-1:0] BEAT_LAST = BEAT_BITS'(NUM_ST_PER_BUS - 1);
  localparam logic [PKT_BITS-1:0]  PKT_LAST  = PKT_BITS'(ST_PER_TURBO_PKT - 1);

  if (!params_legal(BUS, ST_PER_BUS, ST, NUM_ST_PER_BUS,
                    NUM_BUS_PER_TURBO_PKT, ST_PER_TURBO_PKT)) begin : g_param_check
    $error("bus2st_tx: illegal parameter combination");
  end

  logic                  enable_q;
  logic                  err_q;
  logic                  pkt_done_q;
  logic [BEAT_BITS-1:0]  beat_cnt_q, beat_cnt_d;
  logic [WORD_BITS-1:0]  word_cnt_q, word_cnt_d;
  logic [PKT_BITS-1:0]   pkt_beat_q, pkt_beat_d;
  state_e                state_q, state_d;

  logic                  push, pop, xfer, beat_last, pkt_last;
  logic                  full, empty;
  logic [ST_PER_BUS-1:0] rd_data;
  logic [ST-1:0]         slice_w [NUM_ST_PER_BUS];
  logic                  unused_bits;

  // Bits above the payload and the word index are carried but not consumed.
  assign unused_bits = ^{bus_data[BUS-1:ST_PER_BUS], word_cnt_q};

  assign bus_ready = enable_q & ~full;
  assign push      = bus_en & bus_ready;
  assign st_valid  = ~empty;
  assign xfer      = st_valid & st_ready;
  assign beat_last = (beat_cnt_q == BEAT_LAST);
  assign pkt_last  = (pkt_beat_q == PKT_LAST);
  // The eop beat also retires a partially consumed last word.
  assign pop       = xfer & (beat_last | pkt_last);

  bus2st_pingpong #(
    .W (ST_PER_BUS)
  ) u_store (
    .clk       (clk_bus),
    .rst_n     (rst_n),
    .push_i    (push),
    .wr_data_i (bus_data[ST_PER_BUS-1:0]),
    .pop_i     (pop),
    .rd_data_o (rd_data),
    .full_o    (full),
    .empty_o   (empty)
  );

  for (genvar gi = 0; gi < NUM_ST_PER_BUS; gi++) begin : g_slice
    assign slice_w[gi] = rd_data[gi*ST +: ST];
  end

  assign st_data      = slice_w[beat_cnt_q];
  assign st_sop       = st_valid & (state_q == IDLE);
  assign st_eop       = st_valid & pkt_last;
  assign pkt_done     = pkt_done_q;
  assign err_overflow = err_q;

  // Beat/word/packet counters and packet-boundary state; eop wins over end-of-word.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    word_cnt_d = word_cnt_q;
    pkt_beat_d = pkt_beat_q;
    if (xfer) begin
      if (pkt_last) begin
        beat_cnt_d = '0;
        word_cnt_d = '0;
        pkt_beat_d = '0;
        state_d    = IDLE;
      end else begin
        pkt_beat_d = pkt_beat_q + 1'b1;
        state_d    = STREAM;
        if (beat_last) begin
          beat_cnt_d = '0;
          word_cnt_d = word_cnt_q + 1'b1;
        end else begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
    end
  end

  // State, counters, enable, completion pulse and sticky overflow flag.
  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      word_cnt_q <= '0;
      pkt_beat_q <= '0;
      enable_q   <= 1'b0;
      err_q      <= 1'b0;
      pkt_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      word_cnt_q <= word_cnt_d;
      pkt_beat_q <= pkt_beat_d;
      enable_q   <= 1'b1;
      err_q      <= err_q | (bus_en & ~bus_ready);
      pkt_done_q <= xfer & pkt_last;
    end
  end

endmodule

// File: tb/tb_bus2st_tx.sv
// Scoreboard bench for bus2st_tx: expected beats are queued as words are
// written and checked as the stream drains.
module tb_bus2st_tx;

  localparam int BUS  = 534;
  localparam int SPB  = 512;
  localparam int ST   = 8;
  localparam int NST  = 64;
  localparam int NBUS = 25;
  localparam int PKT  = 1542;
  localparam int UPW  = BUS - SPB;
  localparam int MAX_CYC = 20000;

  logic           clk_bus;
  logic           rst_n;
  logic [BUS-1:0] bus_data;
  logic           bus_en;
  logic           bus_ready;
  logic [ST-1:0]  st_data;
  logic           st_valid;
  logic           st_sop;
  logic           st_eop;
  logic           st_ready;
  logic           pkt_done;
  logic           err_overflow;

  bus2st_tx dut (
    .clk_bus      (clk_bus),
    .rst_n        (rst_n),
    .bus_data     (bus_data),
    .bus_en       (bus_en),
    .bus_ready    (bus_ready),
    .st_data      (st_data),
    .st_valid     (st_valid),
    .st_sop       (st_sop),
    .st_eop       (st_eop),
    .st_ready     (st_ready),
    .pkt_done     (pkt_done),
    .err_overflow (err_overflow)
  );

  initial clk_bus = 1'b0;
  always #5 clk_bus = ~clk_bus;

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
    logic       last;
  } beat_t;

  beat_t exp_q[$];
  int    total = 0;
  int    bad   = 0;
  int    gid   = 0;   // global word id, sets the data pattern
  int    wpos  = 0;   // word position within the packet being written
  int    done_pulses = 0;
  bit    done_exp = 0;

  function automatic logic [BUS-1:0] make_word(input int g);
    logic [BUS-1:0] w;
    w = '0;
    for (int k = 0; k < NST; k++) w[k*ST +: ST] = 8'((g * 64 + k) & 255);
    w[BUS-1:SPB] = UPW'($urandom);
    return w;
  endfunction

  task automatic push_expected();
    beat_t e;
    for (int k = 0; k < NST; k++) begin
      int pb;
      pb = wpos * NST + k;
      if (pb < PKT) begin
        e.data = 8'((gid * 64 + k) & 255);
        e.sop  = (pb == 0);
        e.eop  = (pb == PKT - 1);
        e.last = (k == NST - 1) || (pb == PKT - 1);
        exp_q.push_back(e);
      end
    end
    wpos = (wpos == NBUS - 1) ? 0 : wpos + 1;
    gid++;
  endtask

  // Drive words and sink beats. rmode 0: ready always, 1: ready on odd cycles
  // after first valid. wmode 0: write whenever ready, 1: write only into an
  // empty store or on a pop cycle. abort_at >= 0 returns once that many beats
  // have moved. exp_span > 0 checks inclusive cycles from first valid to eop.
  task automatic stream(input int nwords, input int rmode, input int wmode,
                        input int abort_at, input int exp_span);
    int written = 0, cyc = 0, c0 = -1, ceop = -1, xfers = 0;
    bit prev_stall = 0, rdy, xf, pop_now, wr;
    logic [7:0] pd;
    logic ps, pe;
    beat_t e;
    while (cyc < MAX_CYC) begin
      @(negedge clk_bus);
      #1;
      total++;
      if (pkt_done !== done_exp) begin
        bad++;
        $display("FAIL pkt_done cyc=%0d got=%b want=%b", cyc, pkt_done, done_exp);
      end
      if (pkt_done === 1'b1) done_pulses++;
      done_exp = 0;
      if (prev_stall) begin
        total++;
        if ({st_valid, st_data, st_sop, st_eop} !== {1'b1, pd, ps, pe}) begin
          bad++;
          $display("FAIL stall_hold cyc=%0d got=%b/%h/%b/%b want=1/%h/%b/%b",
                   cyc, st_valid, st_data, st_sop, st_eop, pd, ps, pe);
        end
      end
      if (c0 >= 0 && rmode == 0 && exp_q.size() > 0) begin
        total++;
        if (st_valid !== 1'b1) begin
          bad++;
          $display("FAIL bubble cyc=%0d got st_valid=%b want=1", cyc, st_valid);
        end
      end
      if (st_valid === 1'b1) begin
        if (c0 < 0) c0 = cyc;
        rdy = (rmode == 0) ? 1'b1 : (((cyc - c0) % 2) == 1);
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL extra_beat cyc=%0d got data=%h want no beat", cyc, st_data);
        end else if ({st_data, st_sop, st_eop} !== {exp_q[0].data, exp_q[0].sop, exp_q[0].eop}) begin
          bad++;
          $display("FAIL beat idx=%0d got=%h sop=%b eop=%b want=%h sop=%b eop=%b",
                   xfers, st_data, st_sop, st_eop, exp_q[0].data, exp_q[0].sop, exp_q[0].eop);
        end
      end else begin
        rdy = (rmode == 0);
      end
      if (abort_at >= 0 && xfers == abort_at) begin
        st_ready = 1'b0;
        bus_en   = 1'b0;
        return;
      end
      st_ready = rdy;
      xf       = (st_valid === 1'b1) && rdy;
      pop_now  = xf && exp_q.size() > 0 && exp_q[0].last;
      wr = (written < nwords) && (bus_ready === 1'b1) &&
           (wmode == 0 || st_valid !== 1'b1 || pop_now);
      bus_en = wr;
      if (wr) begin
        bus_data = make_word(gid);
        push_expected();
        written++;
      end
      if (xf && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.eop) begin
          done_exp = 1;
          ceop = cyc;
        end
        xfers++;
      end
      prev_stall = (st_valid === 1'b1) && !rdy;
      pd = st_data;
      ps = st_sop;
      pe = st_eop;
      cyc++;
      if (written == nwords && exp_q.size() == 0 && !done_exp) break;
    end
    bus_en   = 1'b0;
    st_ready = 1'b0;
    if (cyc >= MAX_CYC) begin
      total++;
      bad++;
      $display("FAIL timeout got cycles=%0d left=%0d want drained", cyc, exp_q.size());
    end
    if (exp_span > 0) begin
      total++;
      if (ceop - c0 + 1 != exp_span) begin
        bad++;
        $display("FAIL span got=%0d want=%0d", ceop - c0 + 1, exp_span);
      end
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%b want=%b", name, got, want);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus_en = 1'b0; st_ready = 1'b0; bus_data = '0;
    exp_q.delete(); wpos = 0; done_exp = 0;
    repeat (3) @(negedge clk_bus);
    #1;
    check_bit("rst_bus_ready", bus_ready, 1'b0);
    check_bit("rst_st_valid", st_valid, 1'b0);
    check_bit("rst_pkt_done", pkt_done, 1'b0);
    check_bit("rst_err", err_overflow, 1'b0);
    @(negedge clk_bus);
    rst_n = 1'b1;
    #1;
    check_bit("release_bus_ready_early", bus_ready, 1'b0);
    @(negedge clk_bus);
    #1;
    check_bit("release_bus_ready", bus_ready, 1'b1);
    check_bit("idle_st_valid", st_valid, 1'b0);
    check_bit("idle_sop", st_sop, 1'b0);
    $display("reset: total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_stream_full();
    done_pulses = 0;
    stream(25, 0, 0, -1, PKT);
    total++;
    if (done_pulses != 1) begin
      bad++;
      $display("FAIL full_pkt_done_count got=%0d want=1", done_pulses);
    end
    #1;
    check_bit("full_no_tail", st_valid, 1'b0);
    $display("stream_full: total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_stall();
    done_pulses = 0;
    stream(25, 1, 0, -1, 2 * PKT);
    total++;
    if (done_pulses != 1) begin
      bad++;
      $display("FAIL stall_pkt_done_count got=%0d want=1", done_pulses);
    end
    $display("stall: total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_back_to_back();
    done_pulses = 0;
    stream(50, 0, 1, -1, 0);
    total++;
    if (done_pulses != 2) begin
      bad++;
      $display("FAIL b2b_pkt_done_count got=%0d want=2", done_pulses);
    end
    $display("back_to_back: total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_overflow();
    logic br;
    check_bit("ovf_err_before", err_overflow, 1'b0);
    st_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_bus);
      #1;
      br = bus_ready;
      check_bit("ovf_bus_ready", br, (i < 2));
      bus_en   = 1'b1;
      bus_data = make_word(gid);
      if (br === 1'b1) push_expected();
    end
    @(negedge clk_bus);
    bus_en = 1'b0;
    #1;
    check_bit("ovf_err_set", err_overflow, 1'b1);
    check_bit("ovf_sop_held", st_sop, 1'b1);
    repeat (3) begin
      @(negedge clk_bus);
      #1;
      check_bit("ovf_err_sticky", err_overflow, 1'b1);
    end
    done_pulses = 0;
    stream(23, 0, 0, -1, 0);
    total++;
    if (done_pulses != 1) begin
      bad++;
      $display("FAIL ovf_pkt_done_count got=%0d want=1", done_pulses);
    end
    check_bit("ovf_err_end", err_overflow, 1'b1);
    $display("overflow: total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_reset_mid();
    stream(25, 0, 0, 700, 0);
    rst_n = 1'b0;
    #1;
    check_bit("mid_rst_valid", st_valid, 1'b0);
    check_bit("mid_rst_sop", st_sop, 1'b0);
    check_bit("mid_rst_eop", st_eop, 1'b0);
    check_bit("mid_rst_ready", bus_ready, 1'b0);
    check_bit("mid_rst_err", err_overflow, 1'b0);
    exp_q.delete(); wpos = 0; done_exp = 0;
    @(negedge clk_bus);
    #1;
    check_bit("mid_rst_pkt_done", pkt_done, 1'b0);
    rst_n = 1'b1;
    done_pulses = 0;
    stream(25, 0, 0, -1, PKT);
    total++;
    if (done_pulses != 1) begin
      bad++;
      $display("FAIL mid_pkt_done_count got=%0d want=1", done_pulses);
    end
    $display("reset_mid: total=%0d bad=%0d", total, bad);
  endtask

  initial begin
    test_reset();
    test_stream_full();
    test_stall();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
